// File: rtl/sfifo_ctl.sv
// Single-clock FIFO controller with flop storage, occupancy count, watermark flags,
// sticky error flags and selectable standard / first-word-fall-through read.
module sfifo_ctl #(
   parameter int DW       = 24,
   parameter int AW       = 4,
   parameter int PW       = AW + 1,
   parameter int HEADROOM = 2,
   parameter int LOWMARK  = 1,
   parameter int FWFT     = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] data_in,
   output logic          full,
   output logic          alFull,
   input  logic          pop,
   output logic          vld,
   output logic [DW-1:0] data_out,
   output logic          empty,
   output logic          alEmpty,
   output logic [PW-1:0] count,
   output logic          overflow,
   output logic          underflow,
   input  logic          clr_err
);

   localparam int            DEPTH       = 1 << AW;
   localparam logic [PW-1:0] DEPTH_CNT   = PW'(DEPTH);
   localparam logic [PW-1:0] AFULL_MARK  = PW'(DEPTH - HEADROOM);
   localparam logic [PW-1:0] AEMPTY_MARK = PW'(LOWMARK);

   logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [PW-1:0] count_int;
   logic          full_int, empty_int;
   logic          push_ok, pop_ok;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] head;
   logic          overflow_reg, overflow_next;
   logic          underflow_reg, underflow_next;

   // Occupancy and every flag come only from the registered pointers.
   assign count_int = wr_ptr_reg - rd_ptr_reg;
   assign full_int  = (count_int == DEPTH_CNT);
   assign empty_int = (count_int == '0);

   // Acceptance looks at current state only: a same-cycle pop never makes room,
   // and a same-cycle push never supplies data.
   assign push_ok = push & ~full_int;
   assign pop_ok  = pop & ~empty_int;

   assign wr_addr = wr_ptr_reg[AW-1:0];
   assign rd_addr = rd_ptr_reg[AW-1:0];

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_next = rd_ptr_reg + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
      end
   end

   // Storage words are deliberately left out of reset.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_mem
         logic [DW-1:0] word_reg;
         always_ff @(posedge clk) begin
            if (push_ok && (wr_addr == AW'(gi))) word_reg <= data_in;
         end
         assign mem_q[gi] = word_reg;
      end
   endgenerate

   assign head = mem_q[rd_addr];

   generate
      if (FWFT != 0) begin : g_fwft
         // Head entry is presented directly; forced to zero while empty so reset reads 0.
         assign vld      = ~empty_int;
         assign data_out = empty_int ? '0 : head;
      end else begin : g_std
         logic          vld_reg;
         logic [DW-1:0] dout_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_reg  <= 1'b0;
               dout_reg <= '0;
            end else begin
               vld_reg <= pop_ok;
               if (pop_ok) dout_reg <= head;
            end
         end
         assign vld      = vld_reg;
         assign data_out = dout_reg;
      end
   endgenerate

   // A new error event takes priority over a same-cycle clear.
   always_comb begin
      overflow_next  = overflow_reg;
      underflow_next = underflow_reg;
      if (clr_err) begin
         overflow_next  = 1'b0;
         underflow_next = 1'b0;
      end
      if (push && full_int)  overflow_next  = 1'b1;
      if (pop && empty_int)  underflow_next = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

   assign full      = full_int;
   assign empty     = empty_int;
   assign alFull    = (count_int >= AFULL_MARK);
   assign alEmpty   = (count_int <= AEMPTY_MARK);
   assign count     = count_int;
   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;

endmodule

// File: tb/tb_sfifo_ctl.sv
// Directed bench for sfifo_ctl: a standard-mode instance and an FWFT instance
// (DW=8, AW=2, HEADROOM=1, LOWMARK=1) sharing clock and reset.
module tb_sfifo_ctl;

   logic       clk = 1'b0;
   logic       rst_n;
   int         checks = 0;
   int         errs = 0;

   // standard-mode instance
   logic       push, pop, clr_err;
   logic [7:0] din;
   logic       full, alfull, vld, empty, alempty, ovf, unf;
   logic [7:0] dout;
   logic [2:0] cnt;

   // FWFT instance
   logic       push_f, pop_f, clr_f;
   logic [7:0] din_f;
   logic       full_f, alfull_f, vld_f, empty_f, alempty_f, ovf_f, unf_f;
   logic [7:0] dout_f;
   logic [2:0] cnt_f;

   always #5 clk = ~clk;

   sfifo_ctl #(.DW(8), .AW(2), .HEADROOM(1), .LOWMARK(1), .FWFT(0)) dut (
      .clk(clk), .rst_n(rst_n), .push(push), .data_in(din), .full(full), .alFull(alfull),
      .pop(pop), .vld(vld), .data_out(dout), .empty(empty), .alEmpty(alempty),
      .count(cnt), .overflow(ovf), .underflow(unf), .clr_err(clr_err));

   sfifo_ctl #(.DW(8), .AW(2), .HEADROOM(1), .LOWMARK(1), .FWFT(1)) dut_f (
      .clk(clk), .rst_n(rst_n), .push(push_f), .data_in(din_f), .full(full_f), .alFull(alfull_f),
      .pop(pop_f), .vld(vld_f), .data_out(dout_f), .empty(empty_f), .alEmpty(alempty_f),
      .count(cnt_f), .overflow(ovf_f), .underflow(unf_f), .clr_err(clr_f));

   task automatic step();
      @(posedge clk);
      #1;
      $display("t=%0t STD push=%b pop=%b clr=%b din=%h -> vld=%b dout=%h cnt=%0d e=%b ae=%b af=%b f=%b ov=%b un=%b | FWFT push=%b pop=%b din=%h -> vld=%b dout=%h cnt=%0d un=%b",
               $time, push, pop, clr_err, din, vld, dout, cnt, empty, alempty, alfull, full, ovf, unf,
               push_f, pop_f, din_f, vld_f, dout_f, cnt_f, unf_f);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      push = 0; pop = 0; clr_err = 0; din = '0;
      push_f = 0; pop_f = 0; clr_f = 0; din_f = '0;
      #3 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (cnt !== 3'd0)   begin errs++; $display("FAIL reset_count: got %0d want 0", cnt); end
      checks++; if ({empty, full, alfull, alempty} !== 4'b1001) begin errs++; $display("FAIL reset_flags: got e/f/af/ae=%b want 1001", {empty, full, alfull, alempty}); end
      checks++; if ({vld, dout} !== 9'h000) begin errs++; $display("FAIL reset_out: got vld=%b dout=%h want 0/00", vld, dout); end
      checks++; if ({ovf, unf} !== 2'b00) begin errs++; $display("FAIL reset_err: got %b want 00", {ovf, unf}); end
      checks++; if ({vld_f, empty_f, dout_f} !== 10'b01_0000_0000) begin errs++; $display("FAIL reset_fwft: got vld=%b e=%b dout=%h want 0/1/00", vld_f, empty_f, dout_f); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_fill();
      logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic [2:0] exp_flags [4] = '{3'b100, 3'b000, 3'b010, 3'b011}; // {alEmpty, alFull, full}
      for (int i = 0; i < 4; i++) begin
         push = 1; din = vals[i];
         step();
         checks++; if (cnt !== 3'(i + 1)) begin errs++; $display("FAIL fill_count%0d: got %0d want %0d", i, cnt, i + 1); end
         checks++; if ({alempty, alfull, full} !== exp_flags[i]) begin errs++; $display("FAIL fill_flags%0d: got ae/af/f=%b want %b", i, {alempty, alfull, full}, exp_flags[i]); end
      end
      din = 8'h55;
      step();
      push = 0;
      checks++; if (ovf !== 1'b1) begin errs++; $display("FAIL fill_overflow: got %b want 1", ovf); end
      checks++; if (cnt !== 3'd4) begin errs++; $display("FAIL fill_ovf_count: got %0d want 4", cnt); end
   endtask

   task automatic test_drain();
      logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         pop = 1;
         step();
         checks++; if ({vld, dout} !== {1'b1, vals[i]}) begin errs++; $display("FAIL drain%0d: got vld=%b dout=%h want 1/%h", i, vld, dout, vals[i]); end
      end
      checks++; if ({empty, cnt} !== 4'b1_000) begin errs++; $display("FAIL drain_empty: got e=%b cnt=%0d want 1/0", empty, cnt); end
      step();
      pop = 0;
      checks++; if ({vld, dout, unf} !== {1'b0, 8'h44, 1'b1}) begin errs++; $display("FAIL drain_underflow: got vld=%b dout=%h un=%b want 0/44/1", vld, dout, unf); end
      clr_err = 1;
      step();
      clr_err = 0;
      checks++; if ({ovf, unf} !== 2'b00) begin errs++; $display("FAIL clr_both: got %b want 00", {ovf, unf}); end
   endtask

   task automatic test_simultaneous();
      logic [7:0] exp [4] = '{8'hB2, 8'hB3, 8'hB4, 8'hB6};
      push = 1; din = 8'hB0; step();
      din = 8'hB1; step();
      pop = 1; din = 8'hB2; step();
      checks++; if ({cnt, vld, dout} !== {3'd2, 1'b1, 8'hB0}) begin errs++; $display("FAIL sim_mid: got cnt=%0d vld=%b dout=%h want 2/1/b0", cnt, vld, dout); end
      pop = 0; din = 8'hB3; step();
      din = 8'hB4; step();
      pop = 1; din = 8'hB5; step();
      checks++; if ({cnt, ovf, vld, dout} !== {3'd3, 1'b1, 1'b1, 8'hB1}) begin errs++; $display("FAIL sim_full: got cnt=%0d ov=%b vld=%b dout=%h want 3/1/1/b1", cnt, ovf, vld, dout); end
      pop = 0; din = 8'hB6; step();
      clr_err = 1; din = 8'hB7; step();
      checks++; if ({ovf, cnt} !== {1'b1, 3'd4}) begin errs++; $display("FAIL clr_vs_set: got ov=%b cnt=%0d want 1/4", ovf, cnt); end
      push = 0; step();
      clr_err = 0;
      checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL clr_alone: got %b want 0", ovf); end
      pop = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if ({vld, dout} !== {1'b1, exp[i]}) begin errs++; $display("FAIL sim_drain%0d: got vld=%b dout=%h want 1/%h", i, vld, dout, exp[i]); end
      end
      push = 1; din = 8'hC0; step();
      checks++; if ({cnt, unf, vld} !== {3'd1, 1'b1, 1'b0}) begin errs++; $display("FAIL sim_empty: got cnt=%0d un=%b vld=%b want 1/1/0", cnt, unf, vld); end
      push = 0; step();
      pop = 0;
      checks++; if ({vld, dout, cnt} !== {1'b1, 8'hC0, 3'd0}) begin errs++; $display("FAIL sim_empty_pop: got vld=%b dout=%h cnt=%0d want 1/c0/0", vld, dout, cnt); end
      clr_err = 1; step();
      clr_err = 0;
   endtask

   task automatic test_wrap();
      int rx = 0;
      for (int c = 0; c < 43; c++) begin
         push = (c < 40);
         din  = 8'(c);
         pop  = (c >= 2) && (c < 42);
         step();
         if (vld) begin
            checks++; if (dout !== 8'(rx)) begin errs++; $display("FAIL wrap_data%0d: got %h want %h", rx, dout, 8'(rx)); end
            rx++;
         end
      end
      push = 0; pop = 0;
      checks++; if (rx !== 40) begin errs++; $display("FAIL wrap_rx: got %0d want 40", rx); end
      checks++; if ({ovf, unf, cnt, empty} !== 6'b00_000_1) begin errs++; $display("FAIL wrap_end: got ov=%b un=%b cnt=%0d e=%b want 0/0/0/1", ovf, unf, cnt, empty); end
   endtask

   task automatic test_fwft();
      push_f = 1; din_f = 8'hA5; step();
      checks++; if ({vld_f, dout_f, empty_f, cnt_f} !== {1'b1, 8'hA5, 1'b0, 3'd1}) begin errs++; $display("FAIL fwft_latency: got vld=%b dout=%h e=%b cnt=%0d want 1/a5/0/1", vld_f, dout_f, empty_f, cnt_f); end
      push_f = 0; pop_f = 1; step();
      pop_f = 0;
      checks++; if ({vld_f, empty_f} !== 2'b01) begin errs++; $display("FAIL fwft_pop: got vld=%b e=%b want 0/1", vld_f, empty_f); end
      push_f = 1; din_f = 8'h5A; step();
      din_f = 8'h3C; step();
      push_f = 0;
      checks++; if ({dout_f, cnt_f} !== {8'h5A, 3'd2}) begin errs++; $display("FAIL fwft_head: got dout=%h cnt=%0d want 5a/2", dout_f, cnt_f); end
      pop_f = 1; step();
      checks++; if ({vld_f, dout_f} !== {1'b1, 8'h3C}) begin errs++; $display("FAIL fwft_advance: got vld=%b dout=%h want 1/3c", vld_f, dout_f); end
      step(); step();
      pop_f = 0;
      checks++; if ({vld_f, unf_f} !== 2'b01) begin errs++; $display("FAIL fwft_underflow: got vld=%b un=%b want 0/1", vld_f, unf_f); end
   endtask

   task automatic test_midreset();
      push = 1;
      for (int i = 0; i < 5; i++) begin din = 8'hD0 + 8'(i); step(); end
      push = 0; pop = 1; step();
      pop = 0;
      checks++; if ({cnt, vld, dout, ovf} !== {3'd3, 1'b1, 8'hD0, 1'b1}) begin errs++; $display("FAIL pre_reset: got cnt=%0d vld=%b dout=%h ov=%b want 3/1/d0/1", cnt, vld, dout, ovf); end
      rst_n = 1'b0;
      #2;
      checks++; if ({cnt, empty, full, alfull, alempty} !== {3'd0, 4'b1001}) begin errs++; $display("FAIL async_reset_state: got cnt=%0d e/f/af/ae=%b want 0/1001", cnt, {empty, full, alfull, alempty}); end
      checks++; if ({vld, dout, ovf, unf} !== 11'h000) begin errs++; $display("FAIL async_reset_out: got vld=%b dout=%h ov=%b un=%b want 0/00/0/0", vld, dout, ovf, unf); end
      checks++; if ({vld_f, unf_f, cnt_f} !== 5'b00_000) begin errs++; $display("FAIL async_reset_fwft: got vld=%b un=%b cnt=%0d want 0/0/0", vld_f, unf_f, cnt_f); end
      @(negedge clk);
      rst_n = 1'b1;
      push = 1; din = 8'hE0; push_f = 1; din_f = 8'hE1; step();
      push = 0; push_f = 0; pop = 1; step();
      pop = 0;
      checks++; if ({vld, dout, cnt} !== {1'b1, 8'hE0, 3'd0}) begin errs++; $display("FAIL post_reset: got vld=%b dout=%h cnt=%0d want 1/e0/0", vld, dout, cnt); end
      checks++; if ({vld_f, dout_f, cnt_f} !== {1'b1, 8'hE1, 3'd1}) begin errs++; $display("FAIL post_reset_fwft: got vld=%b dout=%h cnt=%0d want 1/e1/1", vld_f, dout_f, cnt_f); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_simultaneous();
      test_wrap();
      test_fwft();
      test_midreset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
